computational_unit_param: RTL and testbench

- Parametrised next-generation computational unit for the team's small microprocessor datapath.
- Holds the X/Y operand register banks, the R result register, the zero and carry flags, the M/I index pair and the output register. Drives the internal data bus from a source mux.
- Adds width/depth generalisation, carry-chained add/subtract, and a multi-cycle shift-add multiplier with a busy handshake to the control unit.

---
 rtl/computational_unit_param.sv | 225 ++++++++++++++++++++++
 tb/tb_computational_unit_param.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/computational_unit_param.sv
// Parametrised computational unit: X/Y operand banks, R/R_HI result pair,
// zero/carry flags, M/I index pair, output port register, bus source mux,
// carry-chained single-cycle ALU and a multi-cycle shift-add multiplier.
module computational_unit_param #(
  parameter int DATA_W = 4,
  parameter int N_XY   = 2,
  parameter int SEL_W  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            source_sel,
  input  logic [4:0]            reg_en,
  input  logic [SEL_W-1:0]      x_sel,
  input  logic [SEL_W-1:0]      y_sel,
  input  logic                  i_sel,
  input  logic [3:0]            alu_op,
  input  logic                  alu_go,
  input  logic [DATA_W-1:0]     imm,
  input  logic [DATA_W-1:0]     dm,
  input  logic [DATA_W-1:0]     i_pins,
  output logic [DATA_W-1:0]     data_bus,
  output logic [DATA_W-1:0]     r,
  output logic [DATA_W-1:0]     r_hi,
  output logic                  r_eq_0,
  output logic                  carry,
  output logic [DATA_W-1:0]     m,
  output logic [DATA_W-1:0]     i,
  output logic [DATA_W-1:0]     o_reg,
  output logic                  busy,
  output logic                  mul_done,
  output logic [2*DATA_W-1:0]   from_cu
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [3:0] OP_NEG = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_RLZ = 4'd7;
  localparam logic [3:0] OP_RRZ = 4'd8;
  localparam logic [3:0] OP_ADC = 4'd9;
  localparam logic [3:0] OP_SBB = 4'd10;

  logic [N_XY-1:0][DATA_W-1:0] x_bank, y_bank;
  logic [DATA_W-1:0]           x_rd, y_rd;

  // multiplier state: prod holds {partial sum, remaining multiplier bits}
  logic [DATA_W-1:0]   mcand;
  logic [2*DATA_W-1:0] prod, prod_nxt;
  logic [DATA_W:0]     mul_sum;
  logic [CNT_W-1:0]    cnt;

  // single-cycle ALU outputs
  logic [DATA_W-1:0] alu_r;
  logic              alu_z, alu_c;
  logic [DATA_W:0]   wide;

  logic issue;

  assign x_rd    = x_bank[x_sel];
  assign y_rd    = y_bank[y_sel];
  assign from_cu = {x_bank[1], x_bank[0]};
  assign issue   = alu_go && !busy;

  // internal bus source mux; unused selects drive zero
  always_comb begin
    case (source_sel)
      4'd0:    data_bus = x_rd;
      4'd1:    data_bus = y_rd;
      4'd2:    data_bus = r;
      4'd3:    data_bus = m;
      4'd4:    data_bus = i;
      4'd5:    data_bus = dm;
      4'd6:    data_bus = imm;
      4'd7:    data_bus = i_pins;
      4'd8:    data_bus = r_hi;
      default: data_bus = '0;
    endcase
  end

  // operand banks: one write port each, indexed by x_sel / y_sel
  genvar g;
  generate
    for (g = 0; g < N_XY; g++) begin : g_bank
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          x_bank[g] <= '0;
          y_bank[g] <= '0;
        end else begin
          if (reg_en[0] && x_sel == SEL_W'(g)) x_bank[g] <= data_bus;
          if (reg_en[1] && y_sel == SEL_W'(g)) y_bank[g] <= data_bus;
        end
      end
    end
  endgenerate

  // M step, I index (bus load or post-increment by M) and output port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m     <= '0;
      i     <= '0;
      o_reg <= '0;
    end else begin
      if (reg_en[2]) m     <= data_bus;
      if (reg_en[3]) i     <= i_sel ? (i + m) : data_bus;
      if (reg_en[4]) o_reg <= data_bus;
    end
  end

  // single-cycle ALU result and flag update; RLZ/RRZ rotate through r_eq_0
  always_comb begin
    alu_r = r;
    alu_z = r_eq_0;
    alu_c = carry;
    wide  = '0;
    case (alu_op)
      OP_NEG: begin
        alu_r = -x_rd;
        alu_c = (x_rd != '0);
        alu_z = (alu_r == '0);
      end
      OP_SUB: begin
        wide  = {1'b0, x_rd} - {1'b0, y_rd};
        alu_r = wide[DATA_W-1:0];
        alu_c = wide[DATA_W];
        alu_z = (alu_r == '0);
      end
      OP_ADD: begin
        wide  = {1'b0, x_rd} + {1'b0, y_rd};
        alu_r = wide[DATA_W-1:0];
        alu_c = wide[DATA_W];
        alu_z = (alu_r == '0);
      end
      OP_XOR: begin
        alu_r = x_rd ^ y_rd;
        alu_z = (alu_r == '0);
      end
      OP_AND: begin
        alu_r = x_rd & y_rd;
        alu_z = (alu_r == '0);
      end
      OP_NOT: begin
        alu_r = ~x_rd;
        alu_z = (alu_r == '0);
      end
      OP_RLZ: begin
        alu_r = {r[DATA_W-2:0], r_eq_0};
        alu_z = r[DATA_W-1];
      end
      OP_RRZ: begin
        alu_r = {r_eq_0, r[DATA_W-1:1]};
        alu_z = r[0];
      end
      OP_ADC: begin
        wide  = {1'b0, x_rd} + {1'b0, y_rd} + {{DATA_W{1'b0}}, carry};
        alu_r = wide[DATA_W-1:0];
        alu_c = wide[DATA_W];
        alu_z = (alu_r == '0);
      end
      OP_SBB: begin
        // a negative difference wraps into bit DATA_W, which is the borrow
        wide  = {1'b0, x_rd} - {1'b0, y_rd} - {{DATA_W{1'b0}}, carry};
        alu_r = wide[DATA_W-1:0];
        alu_c = wide[DATA_W];
        alu_z = (alu_r == '0);
      end
      default: ;
    endcase
  end

  // one shift-add step: add multiplicand into the high half if the current
  // multiplier bit is set, then shift the whole product right by one
  always_comb begin
    mul_sum  = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {mul_sum, prod[DATA_W-1:1]};
  end

  // result/flag registers and multiplier sequencing; alu_go while busy is dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r        <= '0;
      r_hi     <= '0;
      r_eq_0   <= 1'b1;
      carry    <= 1'b0;
      busy     <= 1'b0;
      mul_done <= 1'b0;
      cnt      <= '0;
      mcand    <= '0;
      prod     <= '0;
    end else begin
      mul_done <= 1'b0;
      if (busy) begin
        prod <= prod_nxt;
        cnt  <= cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          r        <= prod_nxt[DATA_W-1:0];
          r_hi     <= prod_nxt[2*DATA_W-1:DATA_W];
          r_eq_0   <= (prod_nxt == '0);
          carry    <= (prod_nxt[2*DATA_W-1:DATA_W] != '0);
          busy     <= 1'b0;
          mul_done <= 1'b1;
          cnt      <= '0;
        end
      end else if (issue) begin
        if (alu_op == OP_MUL) begin
          // operands are captured here so later bank writes cannot disturb them
          mcand <= x_rd;
          prod  <= {{DATA_W{1'b0}}, y_rd};
          cnt   <= '0;
          busy  <= 1'b1;
        end else begin
          r      <= alu_r;
          r_eq_0 <= alu_z;
          carry  <= alu_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_computational_unit_param.sv
// Directed bench for computational_unit_param: table of single-cycle ALU
// vectors plus hand-written multiply, reset-abort, index and wide-config cases.
module tb_computational_unit_param;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // default configuration DUT (DATA_W=4, N_XY=2)
  logic [3:0] source_sel, alu_op, imm, dm, i_pins;
  logic [4:0] reg_en;
  logic       x_sel, y_sel, i_sel, alu_go;
  logic [3:0] data_bus, r, r_hi, m, i, o_reg;
  logic       r_eq_0, carry, busy, mul_done;
  logic [7:0] from_cu;

  computational_unit_param u_dut (
    .clk(clk), .reset_n(reset_n), .source_sel(source_sel), .reg_en(reg_en),
    .x_sel(x_sel), .y_sel(y_sel), .i_sel(i_sel), .alu_op(alu_op), .alu_go(alu_go),
    .imm(imm), .dm(dm), .i_pins(i_pins), .data_bus(data_bus), .r(r), .r_hi(r_hi),
    .r_eq_0(r_eq_0), .carry(carry), .m(m), .i(i), .o_reg(o_reg), .busy(busy),
    .mul_done(mul_done), .from_cu(from_cu)
  );

  // wide configuration DUT (DATA_W=8, N_XY=4)
  logic [3:0]  b_source_sel, b_alu_op;
  logic [4:0]  b_reg_en;
  logic [1:0]  b_x_sel, b_y_sel;
  logic        b_i_sel, b_alu_go;
  logic [7:0]  b_imm, b_dm, b_i_pins;
  logic [7:0]  b_data_bus, b_r, b_r_hi, b_m, b_i, b_o_reg;
  logic        b_r_eq_0, b_carry, b_busy, b_mul_done;
  logic [15:0] b_from_cu;

  computational_unit_param #(.DATA_W(8), .N_XY(4), .SEL_W(2)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .source_sel(b_source_sel), .reg_en(b_reg_en),
    .x_sel(b_x_sel), .y_sel(b_y_sel), .i_sel(b_i_sel), .alu_op(b_alu_op),
    .alu_go(b_alu_go), .imm(b_imm), .dm(b_dm), .i_pins(b_i_pins),
    .data_bus(b_data_bus), .r(b_r), .r_hi(b_r_hi), .r_eq_0(b_r_eq_0),
    .carry(b_carry), .m(b_m), .i(b_i), .o_reg(b_o_reg), .busy(b_busy),
    .mul_done(b_mul_done), .from_cu(b_from_cu)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] x, y, op, er;
    logic       ec, ez;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_en = '0; alu_go = 1'b0; source_sel = 4'd0; i_sel = 1'b0;
    x_sel = 1'b0; y_sel = 1'b0;
  endtask

  task automatic load_xy(input logic is_y, input logic idx, input logic [3:0] v);
    source_sel = 4'd6; imm = v;
    if (is_y) begin y_sel = idx; reg_en = 5'b00010; end
    else      begin x_sel = idx; reg_en = 5'b00001; end
    tick();
    idle();
  endtask

  task automatic run_op(input logic [3:0] op);
    alu_op = op; alu_go = 1'b1; x_sel = 1'b0; y_sel = 1'b0;
    tick();
    alu_go = 1'b0;
  endtask

  initial begin
    int seen;
    // x, y, op, expected r, carry, zero -- rows chain through r/carry state
    tbl[0]  = '{4'hF, 4'h1, 4'd2,  4'h0, 1'b1, 1'b1}; // ADD overflow
    tbl[1]  = '{4'h2, 4'h3, 4'd9,  4'h6, 1'b0, 1'b0}; // ADC with carry in
    tbl[2]  = '{4'h3, 4'h5, 4'd1,  4'hE, 1'b1, 1'b0}; // SUB borrow
    tbl[3]  = '{4'h0, 4'h5, 4'd0,  4'h0, 1'b0, 1'b1}; // NEG of zero
    tbl[4]  = '{4'h7, 4'h9, 4'd10, 4'hE, 1'b1, 1'b0}; // SBB borrow, cin 0
    tbl[5]  = '{4'h9, 4'h1, 4'd10, 4'h7, 1'b0, 1'b0}; // SBB with cin 1
    tbl[6]  = '{4'hC, 4'hA, 4'd4,  4'h6, 1'b0, 1'b0}; // XOR
    tbl[7]  = '{4'hC, 4'h3, 4'd5,  4'h0, 1'b0, 1'b1}; // AND -> zero
    tbl[8]  = '{4'h6, 4'h3, 4'd6,  4'h9, 1'b0, 1'b0}; // NOT
    tbl[9]  = '{4'h6, 4'h3, 4'd7,  4'h2, 1'b0, 1'b1}; // RLZ
    tbl[10] = '{4'h6, 4'h3, 4'd8,  4'h9, 1'b0, 1'b0}; // RRZ
    tbl[11] = '{4'h6, 4'h3, 4'd11, 4'h9, 1'b0, 1'b0}; // no-op
    tbl[12] = '{4'hA, 4'h7, 4'd2,  4'h1, 1'b1, 1'b0}; // ADD carry, nonzero
    tbl[13] = '{4'hA, 4'h7, 4'd15, 4'h1, 1'b1, 1'b0}; // no-op holds carry
    tbl[14] = '{4'h4, 4'h7, 4'd0,  4'hC, 1'b1, 1'b0}; // NEG
    tbl[15] = '{4'hF, 4'h0, 4'd9,  4'h0, 1'b1, 1'b1}; // ADC wraps to zero

    idle(); alu_op = 4'd0; imm = '0; dm = 4'h7; i_pins = 4'h5;
    b_source_sel = '0; b_reg_en = '0; b_x_sel = '0; b_y_sel = '0; b_i_sel = 1'b0;
    b_alu_op = '0; b_alu_go = 1'b0; b_imm = '0; b_dm = '0; b_i_pins = '0;
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // reset state
    chk("rst_r", r, 4'h0);
    chk("rst_rhi", r_hi, 4'h0);
    chk("rst_z", r_eq_0, 1'b1);
    chk("rst_c", carry, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", mul_done, 1'b0);

    // single-cycle ALU table
    for (int k = 0; k < 16; k++) begin
      load_xy(1'b0, 1'b0, tbl[k].x);
      load_xy(1'b1, 1'b0, tbl[k].y);
      run_op(tbl[k].op);
      chk($sformatf("alu%0d_r", k), r, tbl[k].er);
      chk($sformatf("alu%0d_c", k), carry, tbl[k].ec);
      chk($sformatf("alu%0d_z", k), r_eq_0, tbl[k].ez);
    end

    // MUL 0xD * 0xB = 0x8F, with X0 overwrite and alu_go during busy
    load_xy(1'b0, 1'b0, 4'hD);
    load_xy(1'b1, 1'b0, 4'hB);
    run_op(4'd3);
    chk("mul_busy1", busy, 1'b1);
    source_sel = 4'd6; imm = 4'h0; reg_en = 5'b00001; x_sel = 1'b0;
    alu_op = 4'd2; alu_go = 1'b1;
    tick();
    idle();
    chk("mul_busy2", busy, 1'b1);
    chk("mul_xw", from_cu[3:0], 4'h0);
    tick();
    chk("mul_busy3", busy, 1'b1);
    tick();
    chk("mul_busy4", busy, 1'b1);
    chk("mul_nodone4", mul_done, 1'b0);
    chk("mul_r_hold", r, 4'h0);
    tick();
    chk("mul_busy_end", busy, 1'b0);
    chk("mul_done", mul_done, 1'b1);
    chk("mul_r", r, 4'hF);
    chk("mul_rhi", r_hi, 4'h8);
    chk("mul_c", carry, 1'b1);
    chk("mul_z", r_eq_0, 1'b0);
    tick();
    chk("mul_done_pulse", mul_done, 1'b0);
    chk("mul_ign_r", r, 4'hF);
    source_sel = 4'd8;
    #1 chk("bus_rhi", data_bus, 4'h8);
    idle();

    // reset in busy cycle 2 aborts the multiply
    load_xy(1'b0, 1'b0, 4'hD);
    run_op(4'd3);
    tick();
    chk("abort_busy", busy, 1'b1);
    reset_n = 1'b0;
    #2;
    chk("abort_r", r, 4'h0);
    chk("abort_rhi", r_hi, 4'h0);
    chk("abort_z", r_eq_0, 1'b1);
    chk("abort_busy0", busy, 1'b0);
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (mul_done) seen++;
    end
    chk("abort_nodone", seen, 0);
    chk("abort_r_after", r, 4'h0);

    // M/I index stepping and bus sources
    source_sel = 4'd6; imm = 4'h3; reg_en = 5'b00100; tick();
    imm = 4'hE; reg_en = 5'b01000; tick();
    idle();
    chk("m_load", m, 4'h3);
    chk("i_load", i, 4'hE);
    i_sel = 1'b1; reg_en = 5'b01000; tick();
    chk("i_step1", i, 4'h1);
    tick();
    chk("i_step2", i, 4'h4);
    idle();
    source_sel = 4'd4;  #1 chk("bus_i", data_bus, 4'h4);
    source_sel = 4'd5;  #1 chk("bus_dm", data_bus, 4'h7);
    source_sel = 4'd7;  #1 chk("bus_pins", data_bus, 4'h5);
    source_sel = 4'd12; #1 chk("bus_12", data_bus, 4'h0);
    source_sel = 4'd3; reg_en = 5'b10000; tick();
    idle();
    chk("o_reg", o_reg, 4'h3);
    load_xy(1'b0, 1'b1, 4'h5);
    load_xy(1'b0, 1'b0, 4'hA);
    chk("from_cu", from_cu, 8'h5A);

    // wide configuration: X[3] round trip and an 8-bit multiply
    b_source_sel = 4'd6; b_imm = 8'hA5; b_x_sel = 2'd3; b_reg_en = 5'b00001; tick();
    b_imm = 8'h10; b_y_sel = 2'd2; b_reg_en = 5'b00010; tick();
    b_reg_en = '0; b_source_sel = 4'd0;
    #1 chk("w_x3", b_data_bus, 8'hA5);
    b_x_sel = 2'd0;
    #1 chk("w_x0", b_data_bus, 8'h00);
    b_x_sel = 2'd3; b_alu_op = 4'd3; b_alu_go = 1'b1; tick();
    b_alu_go = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !b_mul_done; k++) begin
      tick();
      seen++;
    end
    chk("w_latency", seen, 8);
    chk("w_r", b_r, 8'h50);
    chk("w_rhi", b_r_hi, 8'h0A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
